// File: rtl/atomik_finance_trading_price_tick.sv
// Delta-state accumulator for price ticks: committed base XOR an accumulator of deltas, with undo.
// Define ATOMIK_HISTORY_EN for a HISTORY_DEPTH-deep undo LIFO; otherwise only the last delta can be undone.
module atomik_finance_trading_price_tick #(
  parameter int DATA_WIDTH    = 64,
  parameter int HISTORY_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic                  accumulate_en,
  input  logic                  read_en,
  input  logic                  rollback_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  accumulator_zero
);

  if (HISTORY_DEPTH < 2 || (HISTORY_DEPTH & (HISTORY_DEPTH - 1)) != 0) begin : g_bad_history_depth
    $error("HISTORY_DEPTH must be a power of two >= 2");
  end

  // Commands are level enables sampled each rising edge; at most one executes, by fixed priority.
  typedef enum logic [2:0] {
    CMD_IDLE,
    CMD_LOAD,
    CMD_ROLLBACK,
    CMD_ACCUM,
    CMD_READ
  } cmd_t;

  cmd_t                  cmd;
  logic [DATA_WIDTH-1:0] base;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] undo_delta;
  logic                  undo_ok;

  always_comb begin
    cmd = CMD_IDLE;
    if (load_en)            cmd = CMD_LOAD;
    else if (rollback_en)   cmd = CMD_ROLLBACK;
    else if (accumulate_en) cmd = CMD_ACCUM;
    else if (read_en)       cmd = CMD_READ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base     <= '0;
      acc      <= '0;
      data_out <= '0;
    end else begin
      case (cmd)
        CMD_LOAD: begin
          base <= data_in;
          acc  <= '0;
        end
        CMD_ROLLBACK: begin
          if (undo_ok) acc <= acc ^ undo_delta;
        end
        CMD_ACCUM: acc <= acc ^ data_in;
        CMD_READ: begin
          // Commit: the published state becomes the new base.
          data_out <= base ^ acc;
          base     <= base ^ acc;
          acc      <= '0;
        end
        default: ;
      endcase
    end
  end

  assign accumulator_zero = (acc == '0);

`ifdef ATOMIK_HISTORY_EN
  localparam int PTR_W = $clog2(HISTORY_DEPTH);
  localparam int CNT_W = $clog2(HISTORY_DEPTH + 1);

  logic [DATA_WIDTH-1:0] hist [HISTORY_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      top_ptr;
  logic [CNT_W-1:0]      count;

  assign top_ptr    = wr_ptr - 1'b1;
  assign undo_ok    = (count != '0);
  assign undo_delta = hist[top_ptr];

  // Ring buffer: pushing while full overwrites the oldest slot, count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      case (cmd)
        CMD_LOAD, CMD_READ: begin
          wr_ptr <= '0;
          count  <= '0;
        end
        CMD_ROLLBACK: begin
          if (undo_ok) begin
            wr_ptr <= top_ptr;
            count  <= count - 1'b1;
          end
        end
        CMD_ACCUM: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (count != CNT_W'(HISTORY_DEPTH)) count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Slot contents only matter while counted, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (cmd == CMD_ACCUM) hist[wr_ptr] <= data_in;
  end
`else
  logic [DATA_WIDTH-1:0] last_delta;
  logic                  last_valid;

  assign undo_ok    = last_valid;
  assign undo_delta = last_delta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_delta <= '0;
      last_valid <= 1'b0;
    end else begin
      case (cmd)
        CMD_LOAD, CMD_READ, CMD_ROLLBACK: last_valid <= 1'b0;
        CMD_ACCUM: begin
          last_delta <= data_in;
          last_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_atomik_finance_trading_price_tick.sv
// Randomized and directed bench for atomik_finance_trading_price_tick against a queue-based reference model.
module tb_atomik_finance_trading_price_tick;
  localparam int W = 64;
`ifdef ATOMIK_HISTORY_EN
  localparam int MODEL_DEPTH = 8;
`else
  localparam int MODEL_DEPTH = 1;
`endif

  // clock / reset
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_en = 1'b0;
  logic         accumulate_en = 1'b0;
  logic         read_en = 1'b0;
  logic         rollback_en = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic         accumulator_zero;

  always #5 clk = ~clk;

  atomik_finance_trading_price_tick #(
    .DATA_WIDTH(W),
    .HISTORY_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_en(load_en),
    .accumulate_en(accumulate_en),
    .read_en(read_en),
    .rollback_en(rollback_en),
    .data_in(data_in),
    .data_out(data_out),
    .accumulator_zero(accumulator_zero)
  );

  // reference model and scoreboard
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_base;
  logic [W-1:0] m_acc;
  logic [W-1:0] m_out;
  logic [W-1:0] hist_q[$];
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_base = '0;
    m_acc  = '0;
    m_out  = '0;
    hist_q.delete();
    exp_q.delete();
  endtask

  task automatic model_step(input logic ld, input logic rb, input logic ac, input logic rd,
                            input logic [W-1:0] d);
    if (ld) begin
      m_base = d;
      m_acc  = '0;
      hist_q.delete();
    end else if (rb) begin
      if (hist_q.size() > 0) m_acc ^= hist_q.pop_back();
    end else if (ac) begin
      m_acc ^= d;
      hist_q.push_back(d);
      if (hist_q.size() > MODEL_DEPTH) void'(hist_q.pop_front());
    end else if (rd) begin
      m_out = m_base ^ m_acc;
      exp_q.push_back(m_out);
      m_base = m_out;
      m_acc  = '0;
      hist_q.delete();
    end
  endtask

  // driver: apply one command for one clock, then compare outputs with the model
  task automatic cycle(input logic ld, input logic rb, input logic ac, input logic rd,
                       input logic [W-1:0] d);
    load_en       = ld;
    rollback_en   = rb;
    accumulate_en = ac;
    read_en       = rd;
    data_in       = d;
    @(posedge clk);
    #1;
    load_en       = 1'b0;
    rollback_en   = 1'b0;
    accumulate_en = 1'b0;
    read_en       = 1'b0;
    model_step(ld, rb, ac, rd, d);
    check("acc_zero", W'(accumulator_zero), W'(m_acc == '0));
    if (exp_q.size() > 0) check("read_data", data_out, exp_q.pop_front());
    else check("data_out_hold", data_out, m_out);
  endtask

  logic [W-1:0] rnd;

  initial begin
    model_reset();
    // reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    check("reset_data_out", data_out, '0);
    check("reset_acc_zero", W'(accumulator_zero), W'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_data_out", data_out, '0);
    check("post_reset_acc_zero", W'(accumulator_zero), W'(1));

    // load / accumulate / read
    cycle(1, 0, 0, 0, 64'hAAAA_AAAA_AAAA_AAAA);
    cycle(0, 0, 1, 0, 64'h5555_5555_5555_5555);
    check("acc_nonzero_after_delta", W'(accumulator_zero), W'(0));
    cycle(0, 0, 0, 1, '0);
    check("tp_read_ff", data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("tp_zero_after_commit", W'(accumulator_zero), W'(1));

    // same delta twice is self-inverse
    cycle(0, 0, 1, 0, 64'h1234_5678_90AB_CDEF);
    check("tp_twice_first", W'(accumulator_zero), W'(0));
    cycle(0, 0, 1, 0, 64'h1234_5678_90AB_CDEF);
    check("tp_twice_second", W'(accumulator_zero), W'(1));

    // rollback of a single delta
    cycle(0, 0, 1, 0, 64'h1111_1111_1111_1111);
    cycle(0, 1, 0, 0, '0);
    check("tp_rollback_zero", W'(accumulator_zero), W'(1));
    cycle(0, 0, 0, 1, '0);
    check("tp_rollback_read", data_out, 64'hFFFF_FFFF_FFFF_FFFF);

    // deep rollback: 1, 2, 4 then four rollbacks
    cycle(0, 0, 1, 0, 64'h1);
    cycle(0, 0, 1, 0, 64'h2);
    cycle(0, 0, 1, 0, 64'h4);
    repeat (4) cycle(0, 1, 0, 0, '0);
    cycle(0, 0, 0, 1, '0);
`ifdef ATOMIK_HISTORY_EN
    check("tp_deep_rollback", data_out, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    check("tp_single_rollback", data_out, 64'hFFFF_FFFF_FFFF_FFFC);
`endif

    // rollback with empty history, and zero delta pushed like any other
    cycle(0, 1, 0, 0, '0);
    cycle(0, 0, 1, 0, 64'h0F);
    cycle(0, 0, 1, 0, '0);
    cycle(0, 1, 0, 0, '0);
    check("zero_delta_rollback", W'(accumulator_zero), W'(0));

    // load beats accumulate
    cycle(1, 0, 1, 0, 64'h42);
    check("tp_load_priority_zero", W'(accumulator_zero), W'(1));
    cycle(0, 0, 0, 1, '0);
    check("tp_load_priority_read", data_out, 64'h42);

    // rollback beats accumulate and read
    cycle(0, 0, 1, 0, 64'h100);
    cycle(0, 1, 1, 1, 64'h300);
    cycle(0, 0, 0, 0, '0);

    // asynchronous reset mid-sequence, with enables high
    cycle(0, 0, 1, 0, 64'hDEAD_BEEF);
    load_en       = 1'b1;
    accumulate_en = 1'b1;
    data_in       = 64'h77;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_data_out", data_out, '0);
    check("async_reset_acc_zero", W'(accumulator_zero), W'(1));
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    load_en       = 1'b0;
    accumulate_en = 1'b0;
    model_reset();
    cycle(0, 1, 0, 0, '0);
    cycle(0, 0, 0, 1, '0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rnd = ($urandom_range(0, 7) == 0) ? '0 : {$urandom, $urandom};
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, rnd);
    end
    cycle(0, 0, 0, 1, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/atomik_finance_trading_price_tick.md
Name: atomik_finance_trading_price_tick

Overview:
- Delta-state accumulator for price-tick streams.
- Holds a committed base state plus an XOR accumulator of deltas. Exposes the reconstructed state (base XOR accumulator) on read.
- Supports undo of recent deltas, and reports when the accumulator is zero.
- Sits between the tick decoder and the order-book state consumers.

Parameters:
- DATA_WIDTH, 64, width of state, deltas and data_out.
- HISTORY_DEPTH, 8, number of deltas retained for rollback. Power of two, >=2. Used only with ATOMIK_HISTORY_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load_en  input  1  load base state from data_in.
- accumulate_en  input  1  XOR data_in into accumulator.
- read_en  input  1  output reconstructed state and commit it.
- rollback_en  input  1  undo most recent uncommitted delta.
- data_in  input  DATA_WIDTH  state value (load) or delta (accumulate).
- data_out  output  DATA_WIDTH  registered reconstructed state.
- accumulator_zero  output  1  high when accumulator == 0.

Behaviour:
- Reset (async, rst_n=0):
  - base=0, acc=0, data_out=0.
  - History empty, count=0.
  - accumulator_zero=1.
- All other updates occur on the rising clk edge.
- Command priority when several enables are high: load_en > rollback_en > accumulate_en > read_en. Only the highest-priority command executes that cycle.
- LOAD:
  - base <= data_in; acc <= 0; history cleared.
  - data_out unchanged.
- ACCUMULATE:
  - acc <= acc ^ data_in.
  - data_in is pushed onto the history.
  - If history is full, the oldest entry is discarded (circular buffer); count saturates at HISTORY_DEPTH.
- ROLLBACK:
  - If count>0: acc <= acc ^ newest entry; entry popped; count decrements.
  - If count==0: no-op.
- READ:
  - data_out <= base ^ acc, valid the cycle after read_en is sampled.
  - Same edge: base <= base ^ acc; acc <= 0; history cleared (commit). Rollback cannot cross a read.
- data_out holds its value until the next READ or reset.
- accumulator_zero is combinational from the acc register (acc == 0). It updates in the same cycle acc changes.
- Pure XOR arithmetic, no carries, full DATA_WIDTH.
  - Applying the same delta twice restores acc (self-inverse).
  - A zero delta is pushed to history like any other.
- Idle cycles (no enable high): all state holds.
- Reset asserted mid-sequence clears everything immediately, regardless of enables.

Optional Feature:
- ATOMIK_HISTORY_EN defined:
  - Rollback history is a HISTORY_DEPTH-entry LIFO with circular overwrite of the oldest entry.
  - Successive rollbacks undo successive deltas, newest first.
- ATOMIK_HISTORY_EN undefined:
  - History is a single register holding the last accumulated delta plus a valid bit.
  - Rollback XORs it out and clears the valid bit. A second rollback is a no-op.
  - HISTORY_DEPTH is ignored.
- All other behaviour is identical in both builds.

Test Plan:
- Reset 2 cycles, release -> data_out=0, accumulator_zero=1.
- Load 0xAAAAAAAAAAAAAAAA, accumulate 0x5555555555555555, read -> data_out=0xFFFFFFFFFFFFFFFF next cycle, accumulator_zero=1 after commit.
- After commit, accumulate 0x1234567890ABCDEF twice on separate cycles -> accumulator_zero=0 after first, 1 after second.
- Accumulate 0x1111111111111111, then rollback -> accumulator_zero=1. Subsequent read -> data_out=0xFFFFFFFFFFFFFFFF.
- With ATOMIK_HISTORY_EN: accumulate 0x1, 0x2, 0x4, then rollback three times -> acc after each rollback = 0x3, 0x1, 0x0. A fourth rollback is a no-op.
- Simultaneous load_en=1 and accumulate_en=1, data_in=0x42 -> base=0x42, acc=0, accumulator_zero=1. Read gives 0x42.
